// File: rtl/fp_pkg.sv
// fp_pkg: shared state encoding and constants for the FP adder sequencer
package fp_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, ABORT, RESULT} state_t;
    localparam int unsigned FP_TIMEOUT_CYCLES = 64;
    localparam logic [31:0] FP_NAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: operand request and result handshake bundle
interface fp_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_timeout;
    logic        busy;
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_timeout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_timeout, busy
    );
endinterface

// File: rtl/fp_timeout_counter.sv
// fp_timeout_counter: counts WAIT cycles and flags the last allowed one
module fp_timeout_counter
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = FP_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: feeds operand pairs to a serial fp_adder and returns the sum or a timeout NaN
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = FP_TIMEOUT_CYCLES,
    parameter logic [31:0] NAN_RESULT     = FP_NAN
) (
    input  logic                clk,
    input  logic                reset_n,
    fp_add_sequencer_if.slave   bus,
    output logic [31:0]         adder_data,
    output logic                adder_start,
    output logic                adder_reset,
    input  logic                adder_finished,
    input  logic [31:0]         adder_result
);
    state_t      state, state_n;
    logic [31:0] a_q, b_q, data_q;
    logic        expired;
    fp_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != WAIT),
        .enable  (state == WAIT && !adder_finished),
        .expired (expired)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? LOAD_A : IDLE;
            LOAD_A:  state_n = LOAD_B;
            LOAD_B:  state_n = WAIT;
            WAIT:    state_n = adder_finished ? RESULT : expired ? ABORT : WAIT;
            ABORT:   state_n = RESULT;
            RESULT:  state_n = bus.out_ready ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            data_q          <= '0;
            bus.out_result  <= '0;
            bus.out_timeout <= 1'b0;
            adder_reset     <= 1'b1;
        end else begin
            state       <= state_n;
            data_q      <= adder_data;
            adder_reset <= state_n == ABORT;
            if (state == IDLE && bus.in_valid) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            if (state == WAIT && adder_finished) begin
                bus.out_result  <= adder_result;
                bus.out_timeout <= 1'b0;
            end else if (state_n == ABORT) begin
                bus.out_result  <= NAN_RESULT;
                bus.out_timeout <= 1'b1;
            end
        end
    end
    // the adder bus keeps its last word outside the two load cycles
    assign adder_data    = state == LOAD_A ? a_q : state == LOAD_B ? b_q : data_q;
    assign adder_start   = state == LOAD_A;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == RESULT;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed scoreboard bench with a behavioural fp_adder model
module tb_fp_add_sequencer;
    import fp_pkg::*;
    localparam int unsigned TO = 8;
    typedef struct {
        logic [31:0] r;
        logic        t;
        bit          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] adder_data, adder_result;
    logic        adder_start, adder_reset, adder_finished;
    fp_add_sequencer_if bus();
    fp_add_sequencer #(.TIMEOUT_CYCLES(TO), .NAN_RESULT(FP_NAN)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .adder_data     (adder_data),
        .adder_start    (adder_start),
        .adder_reset    (adder_reset),
        .adder_finished (adder_finished),
        .adder_result   (adder_result)
    );
    always #5 clk = ~clk;
    int          errors = 0, checks = 0, cyc = 0, fin_cyc = -100, start_cnt = 0, pairs = 0;
    exp_t        sb[$];
    int          fin_delay = 0, spur_req = 0;
    logic [31:0] mres = '0, exp_a = '0, exp_b = '0;
    bit          spur_b = 1'b0;
    always @(posedge clk) cyc++;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // model adder: latches A/B, optionally pulses a junk finished on B, then finishes after fin_delay
    initial begin
        int          cnt_down, spur_ack;
        bit          phase;
        logic [31:0] a_seen;
        cnt_down = -1; spur_ack = 0; phase = 1'b0; a_seen = '0;
        adder_finished = 1'b0;
        adder_result = '0;
        forever begin
            tick();
            adder_finished = 1'b0;
            if (!reset_n) begin
                phase = 1'b0;
                cnt_down = -1;
            end else begin
                if (spur_req != spur_ack) begin
                    spur_ack = spur_req;
                    adder_finished = 1'b1;
                    adder_result = 32'hDEAD_BEEF;
                end
                if (cnt_down > 0) begin
                    cnt_down--;
                    if (cnt_down == 0) begin
                        adder_finished = 1'b1;
                        adder_result = mres;
                        fin_cyc = cyc;
                        cnt_down = -1;
                    end
                end
                if (phase) begin
                    phase = 1'b0;
                    check("adder_data A", a_seen, exp_a);
                    check("adder_data B", adder_data, exp_b);
                    check("adder_start in LOAD_B", {31'b0, adder_start}, 32'd0);
                    if (spur_b) begin
                        adder_finished = 1'b1;
                        adder_result = 32'hBAD0_0000;
                    end
                    cnt_down = fin_delay > 0 ? fin_delay : -1;
                end else if (adder_start) begin
                    start_cnt++;
                    a_seen = adder_data;
                    phase = 1'b1;
                end
            end
        end
    end
    // monitor: compares every presented result against the head of the scoreboard
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected out_valid: result %h timeout %b, none expected", bus.out_result, bus.out_timeout);
                end else begin
                    e = sb[0];
                    check("out_result", bus.out_result, e.r);
                    check("out_timeout", {31'b0, bus.out_timeout}, {31'b0, e.t});
                    if (!prev && e.lat) check("out_valid latency", cyc, fin_cyc + 1);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            prev = bus.out_valid;
        end
    end
    task automatic send(input logic [31:0] a, input logic [31:0] b, input int dly, input logic [31:0] res,
                        input bit to, input bit push, input bit lat, input bit sbs, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
        check("handshake", {31'b0, ok}, 32'd1);
        if (!keep) bus.in_valid = 1'b0;
        pairs++;
        check("adder_start latency", {31'b0, adder_start}, 32'd1);
        exp_a = a; exp_b = b; fin_delay = dly; mres = res; spur_b = sbs;
        if (push) sb.push_back('{r: to ? FP_NAN : res, t: to, lat: lat});
    endtask
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = !bus.busy && sb.size() == 0;
        end
        check("drain to idle", {31'b0, ok}, 32'd1);
    endtask
    task automatic watch_reset(input int exp_first);
        int first, highs;
        first = -1; highs = 0;
        for (int k = 1; k <= 20; k++) begin
            if (adder_reset) begin
                highs++;
                if (first < 0) first = k;
            end
            tick();
        end
        check("adder_reset first cycle", first, exp_first);
        check("adder_reset pulses", highs, exp_first < 0 ? 0 : 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bit ok;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset out_result", bus.out_result, 32'd0);
        check("reset out_timeout", {31'b0, bus.out_timeout}, 32'd0);
        check("reset adder_start", {31'b0, adder_start}, 32'd0);
        check("reset adder_data", adder_data, 32'd0);
        check("reset adder_reset", {31'b0, adder_reset}, 32'd1);
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("adder_reset release", {31'b0, adder_reset}, 32'd0);
        // 1.0 + 2.0 = 3.0, finished 5 cycles after B
        send(32'h3F80_0000, 32'h4000_0000, 5, 32'h4040_0000, 0, 1, 1, 0, 0);
        wait_idle();
        // -5.0 + 5.0 = 0.0 with the consumer stalled for 10 cycles
        bus.out_ready = 1'b0;
        send(32'hC0A0_0000, 32'h40A0_0000, 3, 32'h0000_0000, 0, 1, 1, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.out_valid;
            if (!ok) tick();
        end
        check("stall out_valid seen", {31'b0, ok}, 32'd1);
        repeat (10) begin
            check("stall in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("stall out_valid", {31'b0, bus.out_valid}, 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle();
        // adder never finishes: abort after 8 WAIT cycles
        send(32'h4040_0000, 32'h3F80_0000, 0, 32'h0, 1, 1, 0, 0, 0);
        watch_reset(11);
        wait_idle();
        // finished on the same cycle as expiry: the sum wins
        send(32'h3F80_0000, 32'h3F80_0000, 8, 32'h4000_0000, 0, 1, 1, 0, 0);
        watch_reset(-1);
        wait_idle();
        // reset while waiting discards the pair
        send(32'h4000_0000, 32'h4000_0000, 0, 32'h0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        check("busy in WAIT", {31'b0, bus.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid reset busy", {31'b0, bus.busy}, 32'd0);
        check("mid reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid reset adder_reset", {31'b0, adder_reset}, 32'd1);
        tick();
        check("held reset adder_reset", {31'b0, adder_reset}, 32'd1);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("post reset adder_reset", {31'b0, adder_reset}, 32'd0);
        send(32'h4000_0000, 32'h4000_0000, 4, 32'h4080_0000, 0, 1, 1, 0, 0);
        wait_idle();
        // spurious finished in IDLE and LOAD_B, then back-to-back pairs
        spur_req++;
        repeat (3) tick();
        check("spurious idle busy", {31'b0, bus.busy}, 32'd0);
        send(32'h4040_0000, 32'h3F80_0000, 2, 32'h4080_0000, 0, 1, 1, 1, 1);
        send(32'h40A0_0000, 32'h40A0_0000, 3, 32'h4120_0000, 0, 1, 1, 0, 0);
        wait_idle();
        check("adder_start pulse count", start_cnt, pairs);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the number of WAIT cycles allowed for adder_finished before abort.
REQ-002 The block SHALL have parameter NAN_RESULT, default 32'h7FC00000, giving the result word returned on timeout.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset.
REQ-004 clk  input  1  the single clock; all state is updated on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  an operand pair is offered.
REQ-007 in_ready  output  1  the sequencer accepts the operand pair this cycle.
REQ-008 in_a, in_b  input  32 each  IEEE-754 single operands A and B.
REQ-009 out_valid  output  1  the result is held for the consumer.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 out_result  output  32  sum word.
REQ-012 out_timeout  output  1  the result is NAN_RESULT because of a timeout.
REQ-013 adder_data  output  32  drives fp_adder data_in.
REQ-014 adder_start  output  1  drives fp_adder start.
REQ-015 adder_reset  output  1  active-high reset to fp_adder.
REQ-016 adder_finished  input  1  fp_adder finished.
REQ-017 adder_result  input  32  fp_adder data_out.
REQ-018 busy  output  1  the sequencer is in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, WAIT, ABORT and RESULT; every output SHALL be registered or decoded from state and registers only.
REQ-020 in_ready SHALL be 1 only in IDLE. On in_valid&&in_ready, in_a and in_b SHALL be captured and the FSM SHALL go to LOAD_A.
REQ-021 In LOAD_A the block SHALL drive adder_start=1 and adder_data=A for exactly one cycle, then go to LOAD_B.
REQ-022 In LOAD_B the block SHALL drive adder_start=0 and adder_data=B for one cycle, then go to WAIT with the timeout counter at 0.
REQ-023 In all other states adder_data SHALL hold its last value and adder_start SHALL be 0.
REQ-024 In WAIT, adder_finished=1 SHALL capture adder_result into out_result, clear out_timeout and move to RESULT.
REQ-025 In WAIT without adder_finished, the counter SHALL increment. When the counter equals TIMEOUT_CYCLES-1, the FSM SHALL move to ABORT.
REQ-026 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-027 If adder_finished and the timeout arrive in the same cycle, finished SHALL win.
REQ-028 adder_finished outside WAIT SHALL be ignored.
REQ-029 ABORT SHALL last one cycle: adder_reset=1, out_result=NAN_RESULT, out_timeout=1, then go to RESULT.
REQ-030 In RESULT, out_valid SHALL be 1 and out_result/out_timeout SHALL be stable until out_ready. On out_ready the FSM SHALL return to IDLE.
REQ-031 RESULT→IDLE→LOAD_A SHALL give a minimum 1-cycle gap between results; there is no input/output overlap.
REQ-032 Latency: a handshake at cycle 0 SHALL give adder_start at cycle 1 and B at cycle 2. adder_finished at cycle N SHALL give out_valid at cycle N+1.

Reset
REQ-033 While reset_n=0 the block SHALL force state=IDLE, counter=0, out_valid=0, out_result=0, out_timeout=0, adder_start=0, adder_data=0, adder_reset=1.
REQ-034 adder_reset SHALL deassert on the first clk edge after reset_n rises.
REQ-035 Reset mid-operation SHALL discard the pending operands and result without emitting any out_valid.

Structure
REQ-036 The state encoding enum, NAN_RESULT and the default TIMEOUT_CYCLES SHALL live in the shared package fp_pkg.
REQ-037 The timeout counter SHALL be one sub-module, fp_timeout_counter, with clear, enable and expired ports; everything else SHALL be flat.

Verification
REQ-038 Operands 3F800000+40000000 with a model adder finishing 5 cycles after B, returning 40400000 → out_result=40400000, out_timeout=0, out_valid at finished+1.
REQ-039 Operands C0A00000+40A00000, model returns 00000000 with out_ready held low 10 cycles → result held stable, in_ready=0 throughout.
REQ-040 Model never asserts finished, TIMEOUT_CYCLES=8 → ABORT after 8 WAIT cycles, adder_reset pulse of 1 cycle, out_result=7FC00000, out_timeout=1.
REQ-041 finished on the same cycle as the timeout → normal result, no adder_reset.
REQ-042 reset_n low during WAIT → busy=0, out_valid=0, and adder_reset=1 until release; the next pair completes normally.
REQ-043 Spurious finished in IDLE/LOAD_B plus back-to-back in_valid → finished ignored, adder_start exactly one pulse per pair.
